// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-cache read port, the redirect input from branch
// resolution, the hazard-unit back-pressure and the registered IF/ID outputs.
//   master : the fetch stage (drives cache request and IF/ID outputs)
//   slave  : the environment (cache, branch unit, decode)
interface instr_fetch_if;
    logic        icache_ren;    // read request
    logic [29:0] icache_addr;   // word address
    logic [31:0] icache_rdata;  // read data, valid on completion
    logic        icache_stall;  // current access not complete
    logic        redirect;      // branch/jump taken
    logic [31:0] redirect_pc;   // redirect target, bits [1:0] ignored
    logic        id_stall;      // decode cannot accept
    logic        if_valid;      // IF/ID holds a live instruction
    logic [31:0] if_pc;         // PC of if_instr
    logic [31:0] if_instr;      // instruction word

    modport master (
        output icache_ren, icache_addr, if_valid, if_pc, if_instr,
        input  icache_rdata, icache_stall, redirect, redirect_pc, id_stall
    );

    modport slave (
        input  icache_ren, icache_addr, if_valid, if_pc, if_instr,
        output icache_rdata, icache_stall, redirect, redirect_pc, id_stall
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Owns the PC, issues word reads to the instruction cache, absorbs cache
// stalls and decode back-pressure (one-entry skid buffer), and handles
// branch/jump redirects including a redirect that lands while a cache
// access is still outstanding.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instr_fetch_if.master (cache port, redirect, id_stall, IF/ID)
// Parameters:
//   RESET_PC  : first PC fetched after reset
//   BYTE_SWAP : 1 = reverse byte order of cache data, 0 = pass through
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, FULL, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [29:0] addr_reg, addr_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] skid_instr_reg, skid_instr_next;

    logic [31:0] fetch_data;
    logic        ren;
    logic        completion;
    logic        consume;

    generate
        if (BYTE_SWAP) begin : g_swap
            for (genvar gi = 0; gi < 4; gi++) begin : g_byte
                assign fetch_data[8*gi +: 8] = bus.icache_rdata[8*(3-gi) +: 8];
            end
        end else begin : g_pass
            assign fetch_data = bus.icache_rdata;
        end
    endgenerate

    assign ren        = (state_reg == FETCH) || (state_reg == DROP);
    assign completion = ren && !bus.icache_stall;
    assign consume    = out_valid_reg && !bus.id_stall;

    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        out_valid_next  = out_valid_reg;
        out_pc_next     = out_pc_reg;
        out_instr_next  = out_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;

        // A consumed entry empties unless something refills it below.
        if (consume) begin
            out_valid_next = 1'b0;
        end

        if (bus.redirect) begin
            out_valid_next = 1'b0;
            fetch_pc_next  = bus.redirect_pc & ~32'd3;
            // An access that is stalled right now must still be allowed to
            // finish on the old address; its data is thrown away in DROP.
            state_next     = (ren && bus.icache_stall) ? DROP : FETCH;
        end else begin
            unique case (state_reg)
                BOOT: state_next = FETCH;
                FETCH: begin
                    if (completion) begin
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        if (!out_valid_reg || consume) begin
                            out_valid_next = 1'b1;
                            out_pc_next    = fetch_pc_reg;
                            out_instr_next = fetch_data;
                        end else begin
                            skid_pc_next    = fetch_pc_reg;
                            skid_instr_next = fetch_data;
                            state_next      = FULL;
                        end
                    end
                end
                FULL: begin
                    if (consume) begin
                        out_valid_next = 1'b1;
                        out_pc_next    = skid_pc_reg;
                        out_instr_next = skid_instr_reg;
                        state_next     = FETCH;
                    end
                end
                DROP: begin
                    if (completion) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = BOOT;
            endcase
        end

        // The bus address follows fetch_pc except while a pre-redirect
        // access is still pending, where it must stay frozen.
        addr_next = (state_next == DROP) ? addr_reg : fetch_pc_next[31:2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= BOOT;
            fetch_pc_reg   <= RESET_PC;
            addr_reg       <= RESET_PC[31:2];
            out_valid_reg  <= 1'b0;
            out_pc_reg     <= 32'd0;
            out_instr_reg  <= NOP;
            skid_pc_reg    <= 32'd0;
            skid_instr_reg <= NOP;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            addr_reg       <= addr_next;
            out_valid_reg  <= out_valid_next;
            out_pc_reg     <= out_pc_next;
            out_instr_reg  <= out_instr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

    assign bus.icache_ren  = ren;
    assign bus.icache_addr = addr_reg;
    assign bus.if_valid    = out_valid_reg;
    assign bus.if_pc       = out_pc_reg;
    assign bus.if_instr    = out_instr_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized cache stalls, decode stalls and redirects. A transaction-level
// scoreboard tracks the next PC decode must receive and the memory image
// supplies the expected instruction word.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .BYTE_SWAP (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_consumed = 0;

    // Memory image: word 0 holds 0x00000013, other words are scrambled.
    function automatic logic [31:0] mem_word(input logic [29:0] w);
        logic [31:0] b;
        b = {w, 2'b00};
        return 32'h13 ^ (b * 32'h9E37_79B1);
    endfunction

    // Cache returns little-endian bytes; decode wants them reversed.
    function automatic logic [31:0] expect_instr(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc[31:2]);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_comb begin
        bus.icache_rdata = bus.icache_stall ? 32'hDEAD_BEEF : mem_word(bus.icache_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Apply one cycle of inputs, then observe just after the next edge.
    task automatic cyc(input logic st, input logic ids, input logic rd, input logic [31:0] tgt);
        bus.icache_stall = st;
        bus.id_stall     = ids;
        bus.redirect     = rd;
        bus.redirect_pc  = tgt;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    logic [31:0] exp_pc = RESET_PC;
    logic        p_hold = 1'b0, p_redir = 1'b0, p_busy = 1'b0;
    logic [31:0] p_pc, p_instr;
    logic [29:0] p_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc  = RESET_PC;
            p_hold  = 1'b0;
            p_redir = 1'b0;
            p_busy  = 1'b0;
        end else begin
            if (p_hold) begin
                check_val("hold_valid", 32'(bus.if_valid), 32'd1);
                check_val("hold_pc", bus.if_pc, p_pc);
                check_val("hold_instr", bus.if_instr, p_instr);
            end
            if (p_redir) check_val("flush_valid", 32'(bus.if_valid), 32'd0);
            if (p_busy) begin
                check_val("stall_ren", 32'(bus.icache_ren), 32'd1);
                check_val("stall_addr", 32'(bus.icache_addr), 32'(p_addr));
            end
            if (bus.if_valid && !bus.id_stall) begin
                $display("consume pc=%h instr=%h", bus.if_pc, bus.if_instr);
                check_val("sb_pc", bus.if_pc, exp_pc);
                check_val("sb_instr", bus.if_instr, expect_instr(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (bus.redirect) exp_pc = bus.redirect_pc & ~32'd3;
            p_hold  = bus.if_valid & bus.id_stall & ~bus.redirect;
            p_pc    = bus.if_pc;
            p_instr = bus.if_instr;
            p_redir = bus.redirect;
            p_busy  = bus.icache_ren & bus.icache_stall;
            p_addr  = bus.icache_addr;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
        check_val({tag, "_pc"}, bus.if_pc, 32'd0);
        check_val({tag, "_instr"}, bus.if_instr, 32'h0000_0013);
        check_val({tag, "_ren"}, 32'(bus.icache_ren), 32'd0);
        check_val({tag, "_addr"}, 32'(bus.icache_addr), 32'(RESET_PC[31:2]));
    endtask

    initial begin
        bus.icache_stall = 1'b0;
        bus.id_stall     = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'd0;

        // Reset values and boot.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        check_val("boot_ren", 32'(bus.icache_ren), 32'd0);
        cyc(0, 0, 0, 0);
        check_val("fetch_ren", 32'(bus.icache_ren), 32'd1);
        check_val("fetch_valid", 32'(bus.if_valid), 32'd0);
        cyc(0, 0, 0, 0);
        check_val("first_valid", 32'(bus.if_valid), 32'd1);
        check_val("first_pc", bus.if_pc, 32'h0);
        check_val("first_instr", bus.if_instr, 32'h1300_0000);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            check_val("stream_valid", 32'(bus.if_valid), 32'd1);
            check_val("stream_pc", bus.if_pc, 32'(i * 4));
        end

        // Cache stall for three cycles on 0x10.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            check_val("cstall_addr", 32'(bus.icache_addr), 32'h4);
            check_val("cstall_pc", bus.if_pc, 32'hC);
        end
        cyc(0, 0, 0, 0);
        check_val("cstall_done_valid", 32'(bus.if_valid), 32'd1);
        check_val("cstall_done_pc", bus.if_pc, 32'h10);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check_val("pre_skid_pc", bus.if_pc, 32'h1C);

        // Decode stall for two cycles while 0x20 completes into the skid.
        cyc(0, 1, 0, 0);
        check_val("skid_pc", bus.if_pc, 32'h1C);
        check_val("skid_ren", 32'(bus.icache_ren), 32'd0);
        cyc(0, 1, 0, 0);
        check_val("skid_hold_pc", bus.if_pc, 32'h1C);
        check_val("skid_hold_ren", 32'(bus.icache_ren), 32'd0);
        cyc(0, 0, 0, 0);
        check_val("skid_out_pc", bus.if_pc, 32'h20);
        check_val("skid_out_ren", 32'(bus.icache_ren), 32'd1);
        cyc(0, 0, 0, 0);
        check_val("after_skid_pc", bus.if_pc, 32'h24);

        // Redirect to 0x103 while the access to 0x40 is stalled.
        for (int i = 0; i < 32 && bus.icache_addr != 30'h10; i++) cyc(0, 0, 0, 0);
        check_val("reach_0x40", 32'(bus.icache_addr), 32'h10);
        cyc(1, 0, 1, 32'h103);
        check_val("drop_valid", 32'(bus.if_valid), 32'd0);
        check_val("drop_addr", 32'(bus.icache_addr), 32'h10);
        cyc(1, 0, 0, 0);
        check_val("drop_hold_addr", 32'(bus.icache_addr), 32'h10);
        cyc(0, 0, 0, 0);
        check_val("drop_done_valid", 32'(bus.if_valid), 32'd0);
        check_val("drop_done_addr", 32'(bus.icache_addr), 32'h40);
        cyc(0, 0, 0, 0);
        check_val("target_pc", bus.if_pc, 32'h100);

        // Redirect with a completion and id_stall in the same cycle.
        cyc(0, 1, 1, 32'h80);
        check_val("redir_stall_valid", 32'(bus.if_valid), 32'd0);
        check_val("redir_stall_addr", 32'(bus.icache_addr), 32'h20);
        cyc(0, 0, 0, 0);
        check_val("redir_stall_pc", bus.if_pc, 32'h80);
        cyc(0, 0, 0, 0);
        check_val("redir_stall_next", bus.if_pc, 32'h84);

        // Asynchronous reset mid-stream at if_pc 0x3C.
        cyc(0, 0, 1, 32'h30);
        for (int i = 0; i < 16 && !(bus.if_valid && bus.if_pc == 32'h3C); i++) cyc(0, 0, 0, 0);
        check_val("reach_0x3c", bus.if_pc, 32'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        check_val("restart_ren", 32'(bus.icache_ren), 32'd1);
        cyc(0, 0, 0, 0);
        check_val("restart_pc", bus.if_pc, RESET_PC);

        // Randomized traffic, including redirects near the top of memory.
        n_consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : $urandom;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 19) == 0, tgt);
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        check_val("liveness", 32'(n_consumed >= 800), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
